// File: rtl/crtc_6845.sv
`default_nettype none
// ============================================================================
// crtc_6845 : character CRT controller producing MA/RA, syncs, DISEN, CURSOR
// Rev 1.0
// ============================================================================
module crtc_6845 #(
  parameter int MA_W = 14,
  parameter int RA_W = 5
) (
  input  logic            PIXELCLK,
  input  logic            RESET,
  input  logic            CRTC_en,
  input  logic            nCS,
  input  logic            RnW,
  input  logic            A0,
  input  logic [7:0]      pDATA_in,
  output logic [7:0]      pDATA_out,
  output logic [MA_W-1:0] MA,
  output logic [RA_W-1:0] RA,
  output logic            HSYNC,
  output logic            VSYNC,
  output logic            DISEN,
  output logic            CURSOR
);

  localparam int         NREGS     = 18;
  localparam logic [4:0] C_AR_LAST = 5'd17;

  logic [7:0]      regs_q [NREGS];
  logic [7:0]      regs_d [NREGS];
  logic [4:0]      ar_q, ar_d;
  logic [7:0]      hc_q, hc_d;
  logic [6:0]      vc_q, vc_d;
  logic [RA_W-1:0] ra_q, ra_d;
  logic            adj_q, adj_d;
  logic [MA_W-1:0] row_q, row_d;
  logic [MA_W-1:0] ma_q, ma_d;
  logic [4:0]      fc_q, fc_d;
  logic            hdisp_q, hdisp_d;
  logic            vdisp_q, vdisp_d;
  logic [3:0]      hs_cnt_q, hs_cnt_d;
  logic [4:0]      vs_cnt_q, vs_cnt_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            disen_q, disen_d;
  logic            cursor_q, cursor_d;

  logic            w_wr_en;
  logic            w_eol;
  logic            w_new_frame;
  logic            w_row_start;
  logic            w_blink;

  logic [7:0]      w_r0, w_r1, w_r2;
  logic [3:0]      w_hsw, w_vsw;
  logic [6:0]      w_vtot, w_vdisp_rows, w_vsync_row;
  logic [RA_W-1:0] w_vadj, w_max_ra, w_cur_start, w_cur_end;
  logic [1:0]      w_blink_mode;
  logic [MA_W-1:0] w_start_addr, w_cur_addr, w_row_len;
  logic            w_unused_bits;

  always_comb begin
    w_r0         = regs_q[0];
    w_r1         = regs_q[1];
    w_r2         = regs_q[2];
    w_hsw        = regs_q[3][3:0];
    w_vsw        = regs_q[3][7:4];
    w_vtot       = regs_q[4][6:0];
    w_vadj       = RA_W'(regs_q[5][4:0]);
    w_vdisp_rows = regs_q[6][6:0];
    w_vsync_row  = regs_q[7][6:0];
    w_max_ra     = RA_W'(regs_q[9][4:0]);
    w_blink_mode = regs_q[10][6:5];
    w_cur_start  = RA_W'(regs_q[10][4:0]);
    w_cur_end    = RA_W'(regs_q[11][4:0]);
    w_start_addr = MA_W'({regs_q[12][5:0], regs_q[13]});
    w_cur_addr   = MA_W'({regs_q[14][5:0], regs_q[15]});
    w_row_len    = MA_W'(regs_q[1]);
  end

  // R8/R16/R17 and the undecoded high bits are storage only.
  assign w_unused_bits = ^{regs_q[8], regs_q[16], regs_q[17], regs_q[4][7], regs_q[5][7:5],
                           regs_q[6][7], regs_q[7][7], regs_q[9][7:5], regs_q[10][7],
                           regs_q[11][7:5], regs_q[12][7:6]};

  assign w_wr_en = CRTC_en & ~nCS & ~RnW;

  always_comb begin
    ar_d = ar_q;
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    if (w_wr_en) begin
      if (!A0) begin
        ar_d = pDATA_in[4:0];
      end else if (ar_q <= C_AR_LAST) begin
        regs_d[ar_q] = pDATA_in;
      end
    end
  end

  always_comb begin
    pDATA_out = 8'h00;
    if (A0 && (ar_q == 5'd14)) pDATA_out = regs_q[14];
    if (A0 && (ar_q == 5'd15)) pDATA_out = regs_q[15];
  end

  always_comb begin
    hc_d        = hc_q;
    vc_d        = vc_q;
    ra_d        = ra_q;
    adj_d       = adj_q;
    row_d       = row_q;
    ma_d        = ma_q;
    fc_d        = fc_q;
    hdisp_d     = hdisp_q;
    vdisp_d     = vdisp_q;
    hs_cnt_d    = hs_cnt_q;
    vs_cnt_d    = vs_cnt_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    disen_d     = disen_q;
    cursor_d    = cursor_q;
    w_eol       = 1'b0;
    w_new_frame = 1'b0;
    w_row_start = 1'b0;
    w_blink     = 1'b0;

    if (CRTC_en) begin
      // Equality only: an HC already past R0 free-runs through 255 to 0.
      w_eol = (hc_q == w_r0);
      hc_d  = w_eol ? 8'd0 : hc_q + 8'd1;
      ma_d  = ma_q + MA_W'(1);

      if (w_eol) begin
        if (adj_q) begin
          if ((ra_q + RA_W'(1)) == w_vadj) w_new_frame = 1'b1;
          else                             ra_d = ra_q + RA_W'(1);
        end else if (ra_q == w_max_ra) begin
          ra_d  = '0;
          row_d = row_q + w_row_len;
          if (vc_q == w_vtot) begin
            if (w_vadj == '0) w_new_frame = 1'b1;
            else              adj_d = 1'b1;
          end else begin
            vc_d        = vc_q + 7'd1;
            w_row_start = 1'b1;
          end
        end else begin
          ra_d = ra_q + RA_W'(1);
        end

        if (w_new_frame) begin
          vc_d  = 7'd0;
          ra_d  = '0;
          adj_d = 1'b0;
          row_d = w_start_addr;
          fc_d  = fc_q + 5'd1;
        end
        ma_d = row_d;
      end

      if (hc_d == 8'd0)       hdisp_d = (w_r1 != 8'd0);
      else if (hc_d == w_r1)  hdisp_d = 1'b0;

      if (w_new_frame)                                  vdisp_d = (w_vdisp_rows != 7'd0);
      else if (w_row_start && (vc_d == w_vdisp_rows))   vdisp_d = 1'b0;

      if ((hc_d == w_r2) && (w_hsw != 4'd0)) hs_cnt_d = w_hsw;
      else if (hs_cnt_q != 4'd0)             hs_cnt_d = hs_cnt_q - 4'd1;

      // Only a real row advance arms VSYNC, so an unprogrammed chip (every char a new frame) stays quiet.
      if (w_row_start && (vc_d == w_vsync_row))
        vs_cnt_d = (w_vsw == 4'd0) ? 5'd16 : {1'b0, w_vsw};
      else if (w_eol && (vs_cnt_q != 5'd0))
        vs_cnt_d = vs_cnt_q - 5'd1;

      case (w_blink_mode)
        2'b00:   w_blink = 1'b1;
        2'b01:   w_blink = 1'b0;
        2'b10:   w_blink = fc_d[3];
        default: w_blink = fc_d[4];
      endcase

      hsync_d  = (hs_cnt_d != 4'd0);
      vsync_d  = (vs_cnt_d != 5'd0);
      disen_d  = hdisp_d & vdisp_d & ~adj_d;
      cursor_d = disen_d & (ma_d == w_cur_addr) & (ra_d >= w_cur_start) &
                 (ra_d <= w_cur_end) & w_blink;
    end
  end

  always_ff @(posedge PIXELCLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'd0;
      ar_q     <= '0;
      hc_q     <= '0;
      vc_q     <= '0;
      ra_q     <= '0;
      adj_q    <= 1'b0;
      row_q    <= '0;
      ma_q     <= '0;
      fc_q     <= '0;
      hdisp_q  <= 1'b0;
      vdisp_q  <= 1'b0;
      hs_cnt_q <= '0;
      vs_cnt_q <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      disen_q  <= 1'b0;
      cursor_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      ar_q     <= ar_d;
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      ra_q     <= ra_d;
      adj_q    <= adj_d;
      row_q    <= row_d;
      ma_q     <= ma_d;
      fc_q     <= fc_d;
      hdisp_q  <= hdisp_d;
      vdisp_q  <= vdisp_d;
      hs_cnt_q <= hs_cnt_d;
      vs_cnt_q <= vs_cnt_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      disen_q  <= disen_d;
      cursor_q <= cursor_d;
    end
  end

  assign MA     = ma_q;
  assign RA     = ra_q;
  assign HSYNC  = hsync_q;
  assign VSYNC  = vsync_q;
  assign DISEN  = disen_q;
  assign CURSOR = cursor_q;

endmodule
`default_nettype wire
